// File: rtl/keccak_squeeze.sv
// keccak_squeeze
//   Squeeze stage for a Keccak-f[1600] sponge. It accepts a permuted state,
//   streams the first RATE_LANES lanes out as 64-bit words, and asks the
//   permutation core for another permutation whenever the rate runs out
//   before the requested number of lanes has been delivered.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, out_lanes  request strobe and length in lanes (sampled in IDLE)
//   st_valid, st_in   permuted state from the core (lane i = st_in[64*i +: 64])
//   st_ready          squeeze block accepts st_in this cycle
//   perm_req          one-cycle request to permute perm_state again
//   perm_state        held state buffer, fed back to the core
//   dout, dout_valid, dout_ready, dout_last   output lane stream
//   busy              high whenever not IDLE
//   done              one-cycle pulse when the request completes
module keccak_squeeze #(
  parameter int unsigned RATE_LANES = 21,
  parameter int unsigned LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] out_lanes,
  input  logic             st_valid,
  input  logic [1599:0]    st_in,
  output logic             st_ready,
  output logic             perm_req,
  output logic [1599:0]    perm_state,
  output logic [63:0]      dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ST,
    EMIT,
    REQ_PERM,
    DONE
  } state_t;

  localparam logic [4:0]       LAST_IDX = 5'(RATE_LANES - 1);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

  state_t               state;
  state_t               state_next;
  logic [24:0][63:0]    buffer;
  logic [LEN_W-1:0]     remaining;
  logic [4:0]           lane_idx;

  assign perm_state = buffer;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    st_ready   = 1'b0;
    perm_req   = 1'b0;
    dout       = '0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    done       = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (out_lanes == '0) ? DONE : WAIT_ST;
        end
      end
      WAIT_ST: begin
        st_ready = 1'b1;
        if (st_valid) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        dout_valid = 1'b1;
        dout       = buffer[lane_idx];
        dout_last  = (remaining == ONE);
        if (dout_ready) begin
          // Completion is tested before rate exhaustion so a request ending
          // exactly on the last rate lane finishes without a permutation.
          if (remaining == ONE) begin
            state_next = DONE;
          end else if (lane_idx == LAST_IDX) begin
            state_next = REQ_PERM;
          end
        end
      end
      REQ_PERM: begin
        perm_req   = 1'b1;
        state_next = WAIT_ST;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buffer    <= '0;
      remaining <= '0;
      lane_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (out_lanes != '0)) begin
            remaining <= out_lanes;
            lane_idx  <= '0;
          end
        end
        WAIT_ST: begin
          if (st_valid) begin
            buffer   <= st_in;
            lane_idx <= '0;
          end
        end
        EMIT: begin
          if (dout_ready && (remaining != '0)) begin
            remaining <= remaining - ONE;
            lane_idx  <= lane_idx + 5'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_squeeze.sv
// tb_keccak_squeeze
//   Scoreboard bench for keccak_squeeze. Each request pushes the lane sequence
//   it should produce (computed from the list of states supplied) into a
//   queue; a monitor pops and compares on every output handshake, and also
//   checks perm_req/done pulse timing, stall stability and perm_state.
module tb_keccak_squeeze;
  localparam int R  = 21;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] out_lanes;
  logic          st_valid;
  logic [1599:0] st_in;
  logic          st_ready;
  logic          perm_req;
  logic [1599:0] perm_state;
  logic [63:0]   dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          dout_last;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  keccak_squeeze #(.RATE_LANES(R), .LEN_W(LW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .out_lanes  (out_lanes),
    .st_valid   (st_valid),
    .st_in      (st_in),
    .st_ready   (st_ready),
    .perm_req   (perm_req),
    .perm_state (perm_state),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_last  (dout_last),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        exhaust;
  } exp_t;

  exp_t          exp_q[$];
  logic [1599:0] perm_q[$];
  int            checks = 0;
  int            errors = 0;
  int            pop_cnt = 0;
  bit            exp_done_next = 1'b0;
  bit            exp_perm_next = 1'b0;
  int            ready_mode = 0;
  int            pidx = 0;

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_state(input string name, input logic [1599:0] act, input logic [1599:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      for (int j = 0; j < 25; j++) begin
        if (act[64*j +: 64] !== req[64*j +: 64]) begin
          $display("FAIL %s: lane %0d got %h expected %h at %0t", name, j,
                   act[64*j +: 64], req[64*j +: 64], $time);
          break;
        end
      end
    end
  endtask

  // Consumer backpressure: 0 = always ready, 1 = fixed pattern, 2 = random.
  initial begin
    bit pat [8];
    pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    dout_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       dout_ready = 1'b1;
        1: begin
          dout_ready = pat[pidx % 8];
          pidx++;
        end
        default: dout_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor
  initial begin
    bit          pv;
    bit          phs;
    logic [63:0] pd;
    exp_t        pe;
    pv  = 1'b0;
    phs = 1'b0;
    pd  = '0;
    pe  = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk1("perm_req_timing", perm_req, exp_perm_next);
        if (perm_req) begin
          if (perm_q.size() == 0) begin
            chk1("perm_unexpected", 1'b0, 1'b1);
          end else begin
            chk_state("perm_state", perm_state, perm_q.pop_front());
          end
        end
        chk1("done_timing", done, exp_done_next);
        if (pv) begin
          chk1("stall_valid", dout_valid, 1'b1);
          chk64("stall_hold", dout, pd);
        end
        if (phs && !pe.last && !pe.exhaust) chk1("back_to_back", dout_valid, 1'b1);
        exp_perm_next = 1'b0;
        exp_done_next = 1'b0;
        phs = 1'b0;
        pv  = dout_valid && !dout_ready;
        pd  = dout;
        if (dout_valid && dout_ready) begin
          if (exp_q.size() == 0) begin
            chk1("unexpected_lane", 1'b0, 1'b1);
          end else begin
            pe = exp_q.pop_front();
            chk64("dout", dout, pe.data);
            chk1("dout_last", dout_last, pe.last);
            pop_cnt++;
            phs = 1'b1;
            exp_done_next = pe.last;
            exp_perm_next = pe.exhaust;
          end
        end
      end else begin
        pv  = 1'b0;
        phs = 1'b0;
        exp_done_next = 1'b0;
        exp_perm_next = 1'b0;
      end
    end
  end

  // Builds the states a request will consume and queues the expected lanes.
  task automatic plan(input int n, input bit patterned, output logic [1599:0] sts[$]);
    int ns;
    logic [1599:0] tmp;
    exp_t e;
    ns = (n + R - 1) / R;
    sts.delete();
    for (int s = 0; s < ns; s++) begin
      for (int i = 0; i < 25; i++) begin
        tmp[64*i +: 64] = patterned ? ((s == 0) ? 64'(i + 1) : 64'(256 + i))
                                    : {$urandom, $urandom};
      end
      sts.push_back(tmp);
    end
    for (int k = 0; k < n; k++) begin
      tmp       = sts[k / R];
      e.data    = tmp[64*(k % R) +: 64];
      e.last    = (k == n - 1);
      e.exhaust = ((k % R) == R - 1) && (k != n - 1);
      exp_q.push_back(e);
    end
    for (int s = 0; s < ns - 1; s++) perm_q.push_back(sts[s]);
  endtask

  task automatic issue_start(input int n);
    @(posedge clk);
    #1;
    start     = 1'b1;
    out_lanes = LW'(n);
    st_valid  = 1'b1;            // must be ignored in IDLE
    st_in     = {50{$urandom}};
    @(negedge clk);
    chk1("idle_st_ready", st_ready, 1'b0);
    @(posedge clk);
    #1;
    start    = 1'b0;
    st_valid = 1'b0;
    if (n == 0) exp_done_next = 1'b1;
    @(negedge clk);
    chk1("start_to_st_ready", st_ready, n != 0);
    chk1("no_dout_after_start", dout_valid, 1'b0);
    chk1("busy_after_start", busy, 1'b1);
  endtask

  task automatic feed_state(input logic [1599:0] s, input bit poke);
    int t;
    @(posedge clk);
    #1;
    t = 0;
    while (!st_ready && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk1("st_ready_wait", st_ready, 1'b1);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    st_valid = 1'b1;
    st_in    = s;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    st_in    = {50{$urandom}};
    @(negedge clk);
    chk1("state_to_dout_valid", dout_valid, 1'b1);
    if (poke) begin
      @(posedge clk);
      #1;
      start     = 1'b1;
      out_lanes = LW'(7);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic run_req(input int n, input int mode, input bit patterned, input bit poke);
    logic [1599:0] sts[$];
    int base;
    int t;
    ready_mode = mode;
    pidx       = 0;
    base       = pop_cnt;
    plan(n, patterned, sts);
    issue_start(n);
    foreach (sts[s]) feed_state(sts[s], poke && (s == 0));
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk1("request_complete", (exp_q.size() == 0) && !busy, 1'b1);
    chk1("perm_count", perm_q.size() == 0, 1'b1);
    chk1("handshake_count", (pop_cnt - base) == n, 1'b1);
  endtask

  task automatic reset_mid_request();
    logic [1599:0] sts[$];
    int base;
    int t;
    ready_mode = 0;
    base       = pop_cnt;
    plan(5, 1'b1, sts);
    issue_start(5);
    feed_state(sts[0], 1'b0);
    t = 0;
    while (pop_cnt < base + 2 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk1("two_lanes_before_reset", pop_cnt == base + 2, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_dout_valid", dout_valid, 1'b0);
    chk1("abort_st_ready", st_ready, 1'b0);
    chk1("abort_done", done, 1'b0);
    exp_q.delete();
    perm_q.delete();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_lanes = '0;
    st_valid  = 1'b0;
    st_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk64("reset_dout", dout, 64'h0);
    chk1("reset_dout_valid", dout_valid, 1'b0);
    chk1("reset_dout_last", dout_last, 1'b0);
    chk1("reset_busy", busy, 1'b0);
    chk1("reset_st_ready", st_ready, 1'b0);
    chk1("reset_perm_req", perm_req, 1'b0);
    chk1("reset_done", done, 1'b0);
    chk_state("reset_perm_state", perm_state, '0);

    run_req(3, 0, 1'b1, 1'b0);
    run_req(23, 0, 1'b1, 1'b0);
    run_req(21, 0, 1'b1, 1'b0);
    run_req(4, 1, 1'b1, 1'b0);
    run_req(0, 0, 1'b1, 1'b0);
    run_req(10, 2, 1'b1, 1'b1);
    reset_mid_request();
    run_req(2, 0, 1'b0, 1'b0);
    run_req(42, 2, 1'b0, 1'b0);
    run_req(22, 1, 1'b0, 1'b0);
    repeat (12) begin
      run_req($urandom_range(0, 70), $urandom_range(0, 2), 1'b0, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
